// File: rtl/imm_gen_pkg.sv
// Shared opcodes and immediate-format tags for the RV32 immediate generator.
package imm_gen_pkg;

  localparam int unsigned ILEN = 32;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

endpackage

// File: rtl/imm_gen_core.sv
// Combinational RV32 immediate decoder: opcode selects format, inst[31] is the sign.
// U/J formats are decoded only when IMM_GEN_UJ_EN is defined.
module imm_gen_core
  import imm_gen_pkg::*;
(
  input  logic [ILEN-1:0] inst_i,
  output logic [ILEN-1:0] imm_o,
  output imm_type_e       type_o
);

  always_comb begin
    imm_o  = '0;
    type_o = IMM_NONE;
    case (inst_i[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        imm_o  = {{20{inst_i[31]}}, inst_i[31:20]};
        type_o = IMM_I;
      end
      OPC_STORE: begin
        imm_o  = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
        type_o = IMM_S;
      end
      OPC_BRANCH: begin
        imm_o  = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
        type_o = IMM_B;
      end
`ifdef IMM_GEN_UJ_EN
      OPC_LUI, OPC_AUIPC: begin
        imm_o  = {inst_i[31:12], 12'h000};
        type_o = IMM_U;
      end
      OPC_JAL: begin
        imm_o  = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21],
                  1'b0};
        type_o = IMM_J;
      end
`endif
      default: begin
        imm_o  = '0;
        type_o = IMM_NONE;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen.sv
// Registered RV32 immediate generator aligned to the ID/EX boundary; en=0 stalls.
// Optional U/J decode via IMM_GEN_UJ_EN (see imm_gen_core).
module imm_gen
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] imm_out,
  output imm_type_e       imm_type
);

  logic [XLEN-1:0] imm_d, imm_q;
  imm_type_e       type_d, type_q;

  imm_gen_core u_core (
    .inst_i (inst),
    .imm_o  (imm_d),
    .type_o (type_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imm_q  <= '0;
      type_q <= IMM_NONE;
    end else if (en) begin
      imm_q  <= imm_d;
      type_q <= type_d;
    end
  end

  assign imm_out  = imm_q;
  assign imm_type = type_q;

endmodule

// File: tb/tb_imm_gen.sv
// Scoreboard bench for imm_gen: stimulus queues expected results, a monitor checks
// each enabled capture. Define IMM_GEN_UJ_EN to expect U/J decode.
module tb_imm_gen;
  import imm_gen_pkg::*;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] imm;
    imm_type_e   typ;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [31:0] inst = 32'h0;
  logic [31:0] imm_out;
  imm_type_e   imm_type;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  imm_gen #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .inst     (inst),
    .imm_out  (imm_out),
    .imm_type (imm_type)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] e_imm, input imm_type_e e_typ);
    n_cmp++;
    if (imm_out !== e_imm || imm_type !== e_typ) begin
      n_err++;
      $display("FAIL %s: got imm=%08h type=%0d, want imm=%08h type=%0d",
               name, imm_out, imm_type, e_imm, e_typ);
    end
  endtask

  task automatic issue(input logic [31:0] i, input logic [31:0] e_imm, input imm_type_e e_typ);
    exp_t e;
    @(negedge clk);
    inst = i;
    en   = 1'b1;
    e.inst = i;
    e.imm  = e_imm;
    e.typ  = e_typ;
    exp_q.push_back(e);
  endtask

  // Monitor: every edge that captures (en=1, rst=0) must match the oldest expectation.
  always @(posedge clk) begin
    logic cap;
    exp_t e;
    cap = en && !rst;
    #1;
    if (cap) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_capture: got imm=%08h type=%0d, want no capture",
                 imm_out, imm_type);
      end else begin
        e = exp_q.pop_front();
        if (imm_out !== e.imm || imm_type !== e.typ) begin
          n_err++;
          $display("FAIL inst_%08h: got imm=%08h type=%0d, want imm=%08h type=%0d",
                   e.inst, imm_out, imm_type, e.imm, e.typ);
        end
      end
    end
  end

  initial begin
    #1 rst = 1'b1;
    #1 check("reset_async", 32'h0, IMM_NONE);
    @(negedge clk);
    check("reset_held", 32'h0, IMM_NONE);
    rst = 1'b0;
    @(posedge clk);
    #1 check("reset_release", 32'h0, IMM_NONE);

    issue(32'hFAB00013, 32'hFFFFFFAB, IMM_I);
    issue(32'h00000093, 32'h00000000, IMM_I);
    issue(32'hFE512E23, 32'hFFFFFFFC, IMM_S);
    issue(32'h00552623, 32'h0000000C, IMM_S);
    issue(32'hFE029AE3, 32'hFFFFFFF4, IMM_B);
    issue(32'h00A38863, 32'h00000010, IMM_B);
    issue(32'hFFFFFFFF, 32'h00000000, IMM_NONE);
    issue(32'h00000000, 32'h00000000, IMM_NONE);
`ifdef IMM_GEN_UJ_EN
    issue(32'h12345037, 32'h12345000, IMM_U);
    issue(32'h1234506F, 32'h00045922, IMM_J);
`else
    issue(32'h12345037, 32'h00000000, IMM_NONE);
    issue(32'h1234506F, 32'h00000000, IMM_NONE);
`endif
    // Leave a non-zero value registered before stalling.
    issue(32'hFAB00013, 32'hFFFFFFAB, IMM_I);

    @(negedge clk);
    en   = 1'b0;
    inst = 32'h00552623;
    repeat (2) @(posedge clk);
    #1 check("stall_hold", 32'hFFFFFFAB, IMM_I);

    // Mid-stream reset must clear outputs without a clock edge.
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("reset_midstream", 32'h0, IMM_NONE);
    rst = 1'b0;

    issue(32'hFE029AE3, 32'hFFFFFFF4, IMM_B);
    @(negedge clk);
    en = 1'b0;

    repeat (4) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
